// File: rtl/cache_instructions_assoc_pkg.sv
// Shared state encoding, default geometry and address-split helpers for the
// set-associative instruction cache.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RECV
    } state_t;

    localparam int DATA_PER_BEAT = 2;
    localparam int LINE_BYTES    = 32;
    localparam int TAG_BITWIDTH  = 25;

    function automatic logic [63:0] addr_field(input logic [63:0] addr, input int lsb, input int width);
        return (addr >> lsb) & ((64'd1 << width) - 64'd1);
    endfunction

    function automatic logic [63:0] data_ix_of(input logic [63:0] addr, input int word_off, input int dix_w);
        return addr_field(addr, word_off, dix_w);
    endfunction

    function automatic logic [63:0] set_ix_of(input logic [63:0] addr, input int word_off, input int dix_w,
                                              input int set_w);
        return addr_field(addr, word_off + dix_w, set_w);
    endfunction

    function automatic logic [63:0] tag_of(input logic [63:0] addr, input int word_off, input int dix_w,
                                           input int set_w, input int addr_w);
        return addr_field(addr, word_off + dix_w + set_w, addr_w - (word_off + dix_w + set_w));
    endfunction

    // Bursts always start on a line boundary, so the beat index within the line is cleared.
    function automatic logic [63:0] burst_addr_of(input logic [63:0] addr, input int beat_off, input int burst_w);
        return (addr >> beat_off) & ~((64'd1 << burst_w) - 64'd1);
    endfunction

endpackage

// File: rtl/cache_instructions_assoc_way_select.sv
// Tag lookup across the ways of one set: reports a hit and picks a refill victim
// (lowest invalid way first, otherwise the set's round-robin pointer).
module cache_way_select #(
    parameter int WAYS  = 2,
    parameter int TAG_W = 25,
    parameter int WAY_W = 1
) (
    input  logic [WAYS-1:0]       set_valid,
    input  logic [WAYS*TAG_W-1:0] set_tags,
    input  logic [TAG_W-1:0]      req_tag,
    input  logic [WAY_W-1:0]      victim_ptr,
    output logic                  hit,
    output logic [WAY_W-1:0]      hit_way,
    output logic [WAY_W-1:0]      victim_way
);

    logic found_invalid;

    always_comb begin
        hit           = 1'b0;
        hit_way       = '0;
        victim_way    = victim_ptr;
        found_invalid = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (set_valid[w] && (set_tags[w*TAG_W +: TAG_W] == req_tag) && !hit) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!set_valid[w] && !found_invalid) begin
                found_invalid = 1'b1;
                victim_way    = WAY_W'(w);
            end
        end
    end

endmodule

// File: rtl/cache_instructions_assoc.sv
// N-way set-associative read-only instruction cache in front of BurstRAM.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module cache_instructions_assoc
    import cache_pkg::*;
#(
    parameter int ADDRESS_BITWIDTH         = 32,
    parameter int DATA_BITWIDTH            = 32,
    parameter int DATA_IX_IN_LINE_BITWIDTH = 3,
    parameter int SET_IX_BITWIDTH          = 2,
    parameter int WAYS                     = 2,
    parameter int RAM_BURST_DATA_COUNT     = 4,
    parameter int RAM_BURST_DATA_BITWIDTH  = 64,
    parameter int RAM_DEPTH_BITWIDTH       = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 enable,
    input  logic                                 invalidate,
    input  logic [ADDRESS_BITWIDTH-1:0]          address,
    output logic [DATA_BITWIDTH-1:0]             data,
    output logic                                 data_ready,
    output logic                                 busy,
    output logic                                 br_cmd,
    output logic                                 br_cmd_en,
    output logic [RAM_DEPTH_BITWIDTH-1:0]        br_addr,
    output logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_wr_data,
    output logic [RAM_BURST_DATA_BITWIDTH/8-1:0] br_data_mask,
    input  logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_rd_data,
    input  logic                                 br_rd_data_valid,
`ifdef ICACHE_STATS_EN
    output logic [63:0]                          stat_hits,
    output logic [63:0]                          stat_misses,
`endif
    input  logic                                 br_busy
);

    localparam int WORD_OFF       = $clog2(DATA_BITWIDTH / 8);
    localparam int BEAT_OFF       = $clog2(RAM_BURST_DATA_BITWIDTH / 8);
    localparam int WORDS_PER_BEAT = RAM_BURST_DATA_BITWIDTH / DATA_BITWIDTH;
    localparam int LINE_WORDS     = 1 << DATA_IX_IN_LINE_BITWIDTH;
    localparam int SETS           = 1 << SET_IX_BITWIDTH;
    localparam int DIX_W          = DATA_IX_IN_LINE_BITWIDTH;
    localparam int TAG_W          = ADDRESS_BITWIDTH - WORD_OFF - DATA_IX_IN_LINE_BITWIDTH - SET_IX_BITWIDTH;
    localparam int WAY_W          = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int BURST_W        = (RAM_BURST_DATA_COUNT > 1) ? $clog2(RAM_BURST_DATA_COUNT) : 1;
    localparam int BURST_CLR_W    = $clog2(RAM_BURST_DATA_COUNT);

    state_t                          state_q, state_d;
    logic                            busy_q, busy_d;
    logic                            data_ready_q, data_ready_d;
    logic                            br_cmd_en_q, br_cmd_en_d;
    logic [DATA_BITWIDTH-1:0]        data_q, data_d;
    logic [RAM_DEPTH_BITWIDTH-1:0]   br_addr_q, br_addr_d;
    logic [WAYS-1:0][SETS-1:0]       valid_q, valid_d;
    logic [TAG_W-1:0]                tag_q [WAYS][SETS];
    logic [TAG_W-1:0]                tag_d [WAYS][SETS];
    logic [SETS-1:0][WAY_W-1:0]      victim_ptr_q, victim_ptr_d;
    logic [SET_IX_BITWIDTH-1:0]      req_set_q, req_set_d;
    logic [DIX_W-1:0]                req_dix_q, req_dix_d;
    logic [WAY_W-1:0]                victim_q, victim_d;
    logic [BURST_W-1:0]              burst_ix_q, burst_ix_d;
    logic                            inval_pend_q, inval_pend_d;

    logic [DATA_BITWIDTH-1:0]        line_mem [WAYS][SETS][LINE_WORDS];

    logic [SET_IX_BITWIDTH-1:0]      in_set;
    logic [DIX_W-1:0]                in_dix;
    logic [TAG_W-1:0]                in_tag;
    logic [RAM_DEPTH_BITWIDTH-1:0]   in_burst_addr;
    logic [WAYS-1:0]                 set_valid;
    logic [WAYS*TAG_W-1:0]           set_tags;
    logic                            lk_hit;
    logic [WAY_W-1:0]                lk_hit_way;
    logic [WAY_W-1:0]                lk_victim;
    logic                            beat_wr;

    assign in_set        = SET_IX_BITWIDTH'(set_ix_of(64'(address), WORD_OFF, DIX_W, SET_IX_BITWIDTH));
    assign in_dix        = DIX_W'(data_ix_of(64'(address), WORD_OFF, DIX_W));
    assign in_tag        = TAG_W'(tag_of(64'(address), WORD_OFF, DIX_W, SET_IX_BITWIDTH, ADDRESS_BITWIDTH));
    assign in_burst_addr = RAM_DEPTH_BITWIDTH'(burst_addr_of(64'(address), BEAT_OFF, BURST_CLR_W));

    // A concurrent invalidate masks every way, so an IDLE request in that cycle can only miss.
    always_comb begin
        set_valid = '0;
        set_tags  = '0;
        for (int w = 0; w < WAYS; w++) begin
            set_valid[w]                = valid_q[w][in_set] & ~invalidate;
            set_tags[w*TAG_W +: TAG_W]  = tag_q[w][in_set];
        end
    end

    cache_way_select #(
        .WAYS  (WAYS),
        .TAG_W (TAG_W),
        .WAY_W (WAY_W)
    ) u_way_select (
        .set_valid  (set_valid),
        .set_tags   (set_tags),
        .req_tag    (in_tag),
        .victim_ptr (victim_ptr_q[in_set]),
        .hit        (lk_hit),
        .hit_way    (lk_hit_way),
        .victim_way (lk_victim)
    );

    assign beat_wr = (state_q == RECV) && br_rd_data_valid && !rst;

    always_ff @(posedge clk) begin
        if (beat_wr) begin
            for (int j = 0; j < WORDS_PER_BEAT; j++) begin
                line_mem[victim_q][req_set_q][DIX_W'(int'(burst_ix_q) * WORDS_PER_BEAT + j)]
                    <= br_rd_data[j*DATA_BITWIDTH +: DATA_BITWIDTH];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        busy_d       = busy_q;
        data_ready_d = 1'b0;
        br_cmd_en_d  = 1'b0;
        data_d       = data_q;
        br_addr_d    = br_addr_q;
        valid_d      = valid_q;
        tag_d        = tag_q;
        victim_ptr_d = victim_ptr_q;
        req_set_d    = req_set_q;
        req_dix_d    = req_dix_q;
        victim_d     = victim_q;
        burst_ix_d   = burst_ix_q;
        inval_pend_d = inval_pend_q;
        case (state_q)
            IDLE: begin
                if (invalidate) begin
                    valid_d = '0;
                end
                if (enable) begin
                    if (lk_hit) begin
                        data_d       = line_mem[lk_hit_way][in_set][in_dix];
                        data_ready_d = 1'b1;
                    end else begin
                        tag_d[lk_victim][in_set]   = in_tag;
                        valid_d[lk_victim][in_set] = 1'b0;
                        victim_ptr_d[in_set]       = (victim_ptr_q[in_set] == WAY_W'(WAYS - 1)) ?
                                                     '0 : victim_ptr_q[in_set] + WAY_W'(1);
                        req_set_d    = in_set;
                        req_dix_d    = in_dix;
                        victim_d     = lk_victim;
                        br_addr_d    = in_burst_addr;
                        burst_ix_d   = '0;
                        inval_pend_d = 1'b0;
                        busy_d       = 1'b1;
                        state_d      = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (invalidate) begin
                    inval_pend_d = 1'b1;
                end
                if (!br_busy) begin
                    br_cmd_en_d = 1'b1;
                    state_d     = RECV;
                end
            end
            RECV: begin
                if (invalidate) begin
                    inval_pend_d = 1'b1;
                end
                if (br_rd_data_valid) begin
                    if ((int'(req_dix_q) / WORDS_PER_BEAT) == int'(burst_ix_q)) begin
                        data_d       = br_rd_data[(int'(req_dix_q) % WORDS_PER_BEAT) * DATA_BITWIDTH +: DATA_BITWIDTH];
                        data_ready_d = 1'b1;
                    end
                    burst_ix_d = burst_ix_q + BURST_W'(1);
                    if (burst_ix_q == BURST_W'(RAM_BURST_DATA_COUNT - 1)) begin
                        if (inval_pend_q || invalidate) begin
                            valid_d = '0;
                        end else begin
                            valid_d[victim_q][req_set_q] = 1'b1;
                        end
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            data_ready_q <= 1'b0;
            br_cmd_en_q  <= 1'b0;
            data_q       <= '0;
            br_addr_q    <= '0;
            valid_q      <= '0;
            victim_ptr_q <= '0;
            req_set_q    <= '0;
            req_dix_q    <= '0;
            victim_q     <= '0;
            burst_ix_q   <= '0;
            inval_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            data_ready_q <= data_ready_d;
            br_cmd_en_q  <= br_cmd_en_d;
            data_q       <= data_d;
            br_addr_q    <= br_addr_d;
            valid_q      <= valid_d;
            tag_q        <= tag_d;
            victim_ptr_q <= victim_ptr_d;
            req_set_q    <= req_set_d;
            req_dix_q    <= req_dix_d;
            victim_q     <= victim_d;
            burst_ix_q   <= burst_ix_d;
            inval_pend_q <= inval_pend_d;
        end
    end

`ifdef ICACHE_STATS_EN
    logic        acc_hit, acc_miss;
    logic [63:0] stat_hits_q, stat_hits_d, stat_misses_q, stat_misses_d;

    assign acc_hit  = (state_q == IDLE) && enable && lk_hit;
    assign acc_miss = (state_q == IDLE) && enable && !lk_hit;

    always_comb begin
        stat_hits_d   = stat_hits_q;
        stat_misses_d = stat_misses_q;
        if (acc_hit && (stat_hits_q != '1)) begin
            stat_hits_d = stat_hits_q + 64'd1;
        end
        if (acc_miss && (stat_misses_q != '1)) begin
            stat_misses_d = stat_misses_q + 64'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_hits_q   <= '0;
            stat_misses_q <= '0;
        end else begin
            stat_hits_q   <= stat_hits_d;
            stat_misses_q <= stat_misses_d;
        end
    end

    assign stat_hits   = stat_hits_q;
    assign stat_misses = stat_misses_q;
`endif

    assign data         = data_q;
    assign data_ready   = data_ready_q;
    assign busy         = busy_q;
    assign br_cmd       = 1'b0;
    assign br_cmd_en    = br_cmd_en_q;
    assign br_addr      = br_addr_q;
    assign br_wr_data   = '0;
    assign br_data_mask = '0;

endmodule
